// File: rtl/store_buffer_fifo.sv
// Store buffer between MEM and D-cache: coalesces same-address stores, forwards to loads, drains oldest-first.
// Latency: an accepted store is visible to loads the next cycle; head is offered straight from state.
// Backpressure: st_ready drops when full with no drain, or when the store hits the offered head and the cache has not taken it. Byte-mask merging: SB_BYTE_MERGE_EN.
module store_buffer_fifo #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 4,
    parameter int DRAIN_THRESH = DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   st_valid,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic [DATA_W-1:0]      st_data,
`ifdef SB_BYTE_MERGE_EN
    input  logic [DATA_W/8-1:0]    st_be,
    input  logic [DATA_W/8-1:0]    ld_be,
    output logic [DATA_W/8-1:0]    drain_be,
`endif
    output logic                   st_ready,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_addr,
    output logic                   ld_hit,
    output logic [DATA_W-1:0]      ld_data,
    output logic                   drain_valid,
    output logic [ADDR_W-1:0]      drain_addr,
    output logic [DATA_W-1:0]      drain_data,
    input  logic                   drain_ready,
    input  logic                   flush_req,
    output logic                   flush_done,
    output logic                   sb_stall,
    output logic [$clog2(DEPTH):0] sb_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef SB_BYTE_MERGE_EN
    localparam int BE_W  = DATA_W / 8;
`endif

    typedef enum logic {S_IDLE, S_FLUSH} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
`ifdef SB_BYTE_MERGE_EN
    logic [BE_W-1:0]   ent_be   [DEPTH];
`endif
    logic [DEPTH-1:0]  ent_vld;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic [DEPTH-1:0]  st_match;
    logic [DEPTH-1:0]  ld_match;
    logic [DEPTH-1:0]  ld_cover;
    logic [PTR_W-1:0]  coal_idx;
    logic              flushing;
    logic              drain_fire;
    logic              head_blocked;
    logic              coal_hit;
    logic              st_fire;
    logic              coal_fire;
    logic              alloc;

    // Addresses are unique among valid entries, so at most one match per lookup.
    always_comb begin
        st_match = '0;
        ld_match = '0;
        ld_cover = '0;
        coal_idx = '0;
        ld_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef SB_BYTE_MERGE_EN
            ld_cover[i] = ((ld_be & ~ent_be[i]) == '0);
`else
            ld_cover[i] = 1'b1;
`endif
            st_match[i] = ent_vld[i] && (ent_addr[i] == st_addr);
            ld_match[i] = ent_vld[i] && (ent_addr[i] == ld_addr) && ld_cover[i];
            if (st_match[i])
                coal_idx = PTR_W'(i);
            if (ld_match[i])
                ld_data = ent_data[i];
        end
    end

    assign flushing     = (state == S_FLUSH);
    assign drain_valid  = (count != '0) && (flushing || (count >= CNT_W'(DRAIN_THRESH)));
    assign drain_fire   = drain_valid && drain_ready;
    assign drain_addr   = ent_addr[head];
    assign drain_data   = ent_data[head];
`ifdef SB_BYTE_MERGE_EN
    assign drain_be     = ent_be[head];
`endif

    // The offered head is frozen: a store to it either allocates a fresh entry
    // alongside the drain, or waits so the address never appears twice.
    assign head_blocked = st_match[head] && drain_valid;
    assign coal_hit     = (|st_match) && !head_blocked;
    assign st_ready     = coal_hit ||
                          (head_blocked ? drain_fire : ((count < CNT_W'(DEPTH)) || drain_fire));
    assign st_fire      = st_valid && st_ready;
    assign coal_fire    = st_fire && coal_hit;
    assign alloc        = st_fire && !coal_hit;
    assign sb_stall     = st_valid && !st_ready;
    assign ld_hit       = ld_valid && (|ld_match);
    assign sb_count     = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_vld <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            state   <= S_IDLE;
        end else begin
            state <= state_nxt;
            if (drain_fire) begin
                ent_vld[head] <= 1'b0;
                head          <= head + 1'b1;
            end
            // Full buffer: tail == head, so this set overrides the drain's clear.
            if (alloc) begin
                ent_vld[tail] <= 1'b1;
                tail          <= tail + 1'b1;
            end
            case ({alloc, drain_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (alloc) begin
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
`ifdef SB_BYTE_MERGE_EN
            ent_be[tail]   <= st_be;
`endif
        end
        if (coal_fire) begin
`ifdef SB_BYTE_MERGE_EN
            for (int b = 0; b < BE_W; b++) begin
                if (st_be[b])
                    ent_data[coal_idx][b*8 +: 8] <= st_data[b*8 +: 8];
            end
            ent_be[coal_idx] <= ent_be[coal_idx] | st_be;
`else
            ent_data[coal_idx] <= st_data;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (flush_req)
                    state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                if (count == '0) begin
                    state_nxt  = S_IDLE;
                    flush_done = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_store_buffer_fifo.sv
// Randomized bench for store_buffer_fifo against a queue-based reference model (head = index 0).
module tb_store_buffer_fifo;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BW     = DW / 8;
    localparam int DEPTH  = 4;
    localparam int THRESH = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BW-1:0] be;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          drain_valid;
    logic [AW-1:0] drain_addr;
    logic [DW-1:0] drain_data;
    logic          drain_ready;
    logic          flush_req;
    logic          flush_done;
    logic          sb_stall;
    logic [2:0]    sb_count;
`ifdef SB_BYTE_MERGE_EN
    logic [BW-1:0] st_be;
    logic [BW-1:0] ld_be;
    logic [BW-1:0] drain_be;
`endif

    ent_t q[$];
    logic m_flush = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    store_buffer_fifo #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .DRAIN_THRESH(THRESH)
    ) dut (
        .clk(clk), .rst(rst),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
`ifdef SB_BYTE_MERGE_EN
        .st_be(st_be), .ld_be(ld_be), .drain_be(drain_be),
`endif
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .drain_valid(drain_valid), .drain_addr(drain_addr), .drain_data(drain_data),
        .drain_ready(drain_ready), .flush_req(flush_req), .flush_done(flush_done),
        .sb_stall(sb_stall), .sb_count(sb_count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input logic r, input logic sv, input logic [AW-1:0] sa,
                        input logic [DW-1:0] sd, input logic [BW-1:0] sbe, input logic lv,
                        input logic [AW-1:0] la, input logic [BW-1:0] lbe,
                        input logic dr, input logic fr);
        int            cnt;
        int            j;
        int            k;
        logic          e_dv;
        logic          e_dfire;
        logic          e_rdy;
        logic          e_coal;
        logic [BW-1:0] mbe;
        logic [BW-1:0] mlbe;
        ent_t          e;
        mbe  = sbe;
        mlbe = lbe;
`ifndef SB_BYTE_MERGE_EN
        mbe  = '1;
        mlbe = '1;
`endif
        @(negedge clk);
        rst         = r;
        st_valid    = sv;
        st_addr     = sa;
        st_data     = sd;
        ld_valid    = lv;
        ld_addr     = la;
        drain_ready = dr;
        flush_req   = fr;
`ifdef SB_BYTE_MERGE_EN
        st_be       = mbe;
        ld_be       = mlbe;
`endif
        #1;
        cnt = q.size();
        j   = -1;
        k   = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].addr == sa) j = i;
            if (q[i].addr == la && (mlbe & ~q[i].be) == '0) k = i;
        end
        e_dv    = (cnt != 0) && (m_flush || cnt >= THRESH);
        e_dfire = e_dv && dr;
        e_coal  = 1'b0;
        if (j >= 0 && !(j == 0 && e_dv)) begin
            e_coal = 1'b1;
            e_rdy  = 1'b1;
        end else if (j == 0) begin
            e_rdy  = e_dfire;
        end else begin
            e_rdy  = (cnt < DEPTH) || e_dfire;
        end

        if (!r) begin
            chk("st_ready", st_ready, e_rdy);
            chk("sb_stall", sb_stall, sv && !e_rdy);
            chk("sb_count", sb_count, cnt);
            chk("drain_valid", drain_valid, e_dv);
            chk("flush_done", flush_done, m_flush && cnt == 0);
            chk("ld_hit", ld_hit, lv && k >= 0);
            if (e_dv) begin
                chk("drain_addr", drain_addr, q[0].addr);
                chk("drain_data", drain_data, q[0].data);
`ifdef SB_BYTE_MERGE_EN
                chk("drain_be", drain_be, q[0].be);
`endif
            end
            if (lv && k >= 0)
                chk("ld_data", ld_data, q[k].data);
        end

        if (r) begin
            q.delete();
            m_flush = 1'b0;
        end else begin
            if (m_flush && cnt == 0)
                m_flush = 1'b0;
            else if (!m_flush && fr)
                m_flush = 1'b1;
            if (sv && e_rdy && e_coal) begin
                e = q[j];
                for (int b = 0; b < BW; b++)
                    if (mbe[b]) e.data[b*8 +: 8] = sd[b*8 +: 8];
                e.be = e.be | mbe;
                q[j] = e;
            end
            if (e_dfire)
                void'(q.pop_front());
            if (sv && e_rdy && !e_coal) begin
                e.addr = sa;
                e.data = sd;
                e.be   = mbe;
                q.push_back(e);
            end
        end
    endtask

    task automatic do_reset();
        step(1, 0, '0, '0, '1, 0, '0, '1, 0, 0);
        step(1, 0, '0, '0, '1, 0, '0, '1, 0, 0);
    endtask

    task automatic st(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic dr);
        step(0, 1, a, d, '1, 0, '0, '1, dr, 0);
    endtask

    task automatic ld(input logic [AW-1:0] a, input logic dr);
        step(0, 0, '0, '0, '1, 1, a, '1, dr, 0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [AW-1:0] la;
        do_reset();
        ld('h100, 0);                        // post-reset idle outputs

        st('h100, 'hD0, 0); st('h104, 'hD1, 0); st('h108, 'hD2, 0);
        ld('h104, 0);

        do_reset();
        st('h10, 'h11, 0); st('h10, 'h22, 0);
        ld('h10, 0);

        do_reset();
        st('h20, 'hA0, 0); st('h24, 'hA1, 0); st('h28, 'hA2, 0); st('h2C, 'hA3, 0);
        st('h30, 'hA4, 0); st('h30, 'hA4, 0);
        st('h30, 'hA4, 1);
        ld('h30, 0);
        st('h24, 'hB1, 0);                   // head 0x24 offered and not taken

        do_reset();
        st('h40, 'hC0, 0); st('h44, 'hC1, 0); st('h48, 'hC2, 0); st('h4C, 'hC3, 0);
        st('h40, 'hCC, 1);
        ld('h40, 0);

        do_reset();
        st('h50, 'hE0, 0); st('h54, 'hE1, 0); st('h58, 'hE2, 0);
        step(0, 0, '0, '0, '1, 0, '0, '1, 0, 1);
        repeat (6) ld('h54, 1);
        step(0, 0, '0, '0, '1, 0, '0, '1, 0, 1);   // flush on empty buffer
        ld('h50, 0); ld('h50, 0);
        st('h60, 'hF0, 0); st('h64, 'hF1, 0); st('h68, 'hF2, 0);
        step(0, 0, '0, '0, '1, 0, '0, '1, 0, 1);
        ld('h60, 1);
        do_reset();
        ld('h64, 1); ld('h64, 1);

`ifdef SB_BYTE_MERGE_EN
        do_reset();
        step(0, 1, 'h70, 'h0000AAAA, 4'b0011, 0, '0, '1, 0, 0);
        step(0, 1, 'h70, 'hBBBB0000, 4'b1100, 0, '0, '1, 0, 0);
        step(0, 1, 'h74, 'h00001234, 4'b0011, 1, 'h70, 4'b1111, 0, 0);
        step(0, 0, '0, '0, '1, 1, 'h74, 4'b0100, 0, 0);
        step(0, 0, '0, '0, '1, 1, 'h74, 4'b0011, 0, 1);
        repeat (4) step(0, 0, '0, '0, '1, 0, '0, '1, 1, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            ra = 32'h100 + 32'($urandom_range(0, 5)) * 4;
            la = 32'h100 + 32'($urandom_range(0, 5)) * 4;
            step($urandom_range(0, 249) == 0, $urandom_range(0, 1) == 1, ra, $urandom,
                 BW'($urandom), $urandom_range(0, 1) == 1, la, BW'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
